// File: rtl/aes_pkg.sv
// Shared AES definitions: sizing constants, key-schedule FSM states,
// GF(2^8) doubling and the forward S-box table.
package aes_pkg;

  localparam int unsigned AES_NR = 14;
  localparam int unsigned AES_NK = 8;
  localparam int unsigned RK_W   = 128;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_t;

  function automatic logic [7:0] xtime8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box lookup; purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  assign sub = SBOX[data];

endmodule

// File: rtl/aes256_key_sched.sv
// AES-256 key expansion into a 15-entry round-key store, one round key per
// cycle after the key handshake, with a registered read port by round index.
module aes256_key_sched
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [255:0]    key_in,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic [3:0]      rk_idx,
  output logic [RK_W-1:0] rk_out,
  output logic            sched_done
);

  localparam int unsigned NUM_RK = AES_NR + 1;

  ks_state_t       state;
  logic [RK_W-1:0] rk [NUM_RK];
  logic [RK_W-1:0] prev0;
  logic [RK_W-1:0] prev1;
  logic [7:0]      rcon;
  logic [3:0]      rnd;
  logic [31:0]     sub_w;
  logic [31:0]     t_w;
  logic [31:0]     k0, k1, k2, k3;
  logic            accept;

  assign key_ready = (state != EXPAND);
  assign accept    = key_valid && key_ready;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data (prev1[8*b +: 8]),
      .sub  (sub_w[8*b +: 8])
    );
  end

  // SubWord is taken before RotWord; the two commute, so one S-box set serves both round types.
  always_comb begin
    t_w = sub_w;
    if (!rnd[0]) begin
      t_w = {sub_w[23:0], sub_w[31:24]} ^ {rcon, 24'h0};
    end
    k0 = prev0[127:96] ^ t_w;
    k1 = prev0[95:64]  ^ k0;
    k2 = prev0[63:32]  ^ k1;
    k3 = prev0[31:0]   ^ k2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sched_done <= 1'b0;
      prev0      <= '0;
      prev1      <= '0;
      rcon       <= 8'h01;
      rnd        <= '0;
      for (int unsigned i = 0; i < NUM_RK; i++) begin
        rk[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            rk[0]      <= key_in[255:128];
            rk[1]      <= key_in[127:0];
            prev0      <= key_in[255:128];
            prev1      <= key_in[127:0];
            rcon       <= 8'h01;
            rnd        <= 4'd2;
            sched_done <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          rk[rnd] <= {k0, k1, k2, k3};
          prev0   <= prev1;
          prev1   <= {k0, k1, k2, k3};
          rnd     <= rnd + 4'd1;
          if (!rnd[0]) begin
            rcon <= xtime8(rcon);
          end
          if (rnd == 4'(AES_NR)) begin
            sched_done <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rk_out <= '0;
    end else if (rk_idx < 4'(NUM_RK)) begin
      rk_out <= rk[rk_idx];
    end else begin
      rk_out <= '0;
    end
  end

endmodule

// File: tb/tb_aes256_key_sched.sv
// Scoreboard bench for aes256_key_sched: FIPS-197 vectors plus an
// independent expansion model built on a GF(2^8)-derived S-box.
module tb_aes256_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         sched_done;

  always #5 clk = ~clk;

  aes256_key_sched dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .sched_done (sched_done)
  );

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] Z_RK2   = 128'h62636363626363636263636362636363;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] exp;
    int           idx;
  } rd_t;
  rd_t sb[$];

  logic rd_req   = 1'b0;
  logic rd_req_q = 1'b0;

  typedef logic [127:0] rk_arr_t [15];
  logic [7:0] sbox_m [256];
  rk_arr_t    a3_exp;
  rk_arr_t    z_exp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl8(r);
        s = s ^ r;
      end
      sbox_m[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic rk_arr_t expand(input logic [255:0] key);
    logic [31:0]  w [60];
    logic [255:0] tmp = key;
    logic [31:0]  temp;
    logic [7:0]   rc = 8'h01;
    rk_arr_t      res;
    for (int i = 0; i < 8; i++) begin
      w[i] = tmp[255:224];
      tmp  = tmp << 32;
    end
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = gf_mul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        temp = subw(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    for (int r = 0; r < 15; r++) begin
      res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return res;
  endfunction

  always @(posedge clk) rd_req_q <= rd_req;

  always @(negedge clk) begin
    if (rd_req_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got read output with empty scoreboard, expected queued entry");
      end else begin
        rd_t e;
        e = sb.pop_front();
        chk($sformatf("rd_idx%0d", e.idx), rk_out, e.exp);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
    rd_t e;
    rk_idx = idx;
    rd_req = 1'b1;
    e.exp  = exp;
    e.idx  = int'(idx);
    sb.push_back(e);
  endtask

  task automatic run_load(input logic [255:0] k, input bit busy, input int rst_at,
                          input logic [127:0] exp_rk2);
    step();
    key_in    = k;
    key_valid = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      step();
      key_valid = 1'b0;
      key_in    = ~k;
      if (rst_at != 0 && t == rst_at + 1) begin
        chk("rst_key_ready", key_ready, 1);
        chk("rst_sched_done", sched_done, 0);
        chk("rst_rk_out", rk_out, 0);
        reset = 1'b0;
        rd(4'd2, '0);
        return;
      end
      if (t <= 13) begin
        chk($sformatf("busy_key_ready_T%0d", t), key_ready, 0);
        chk($sformatf("sched_done_low_T%0d", t), sched_done, 0);
      end else begin
        chk("sched_done_T14", sched_done, 1);
        chk("key_ready_T14", key_ready, 1);
      end
      if (rst_at != 0 && t == rst_at) reset = 1'b1;
      if (rst_at == 0 && t == 2) rd(4'd2, exp_rk2);
      if (busy && t >= 3 && t <= 10) begin
        key_valid = 1'b1;
        key_in    = {8{32'hdeadbeef}};
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_idx    = '0;
    build_sbox();
    a3_exp = expand(KEY_A3);
    z_exp  = expand('0);

    repeat (3) step();
    chk("reset_key_ready", key_ready, 1);
    chk("reset_sched_done", sched_done, 0);
    chk("reset_rk_out", rk_out, 0);
    reset = 1'b0;
    step();
    rd(4'd5, '0);

    run_load(KEY_A3, 1'b1, 0, A3_RK2);
    step(); rd(4'd14, A3_RK14);
    step(); rd(4'd0, A3_RK0);
    step(); rd(4'd2, A3_RK2);
    step(); rd(4'd3, A3_RK3);
    for (int i = 0; i < 16; i++) begin
      step();
      rd(4'(i), (i < 15) ? a3_exp[i] : 128'h0);
    end

    run_load('0, 1'b0, 0, Z_RK2);
    step(); rd(4'd2, Z_RK2);
    step(); rd(4'd14, z_exp[14]);
    step(); rd(4'd15, '0);

    run_load(KEY_A3, 1'b0, 6, A3_RK2);
    run_load(KEY_A3, 1'b0, 0, A3_RK2);
    step(); rd(4'd14, A3_RK14);
    step(); rd(4'd3, A3_RK3);
    step();
    step();
    step();
    chk("sb_drain", 128'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
